// File: rtl/i2s_transmit.sv
// I2S (Philips format) master transmitter with a one-pair holding buffer.
// sck, ws and sd are all generated from clk; sd and ws change only on sck falling edges.
module i2s_transmit #(
    parameter int SCK_DIV    = 1,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic [WORD_WIDTH-1:0] data_left,
    input  logic [WORD_WIDTH-1:0] data_right,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  sck,
    output logic                  ws,
    output logic                  sd,
    output logic                  underrun
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCK_DIV - 1);

    state_t                state_r;
    logic [7:0]            div_r;
    logic                  sck_r;
    logic                  ws_r;
    logic                  underrun_r;
    logic [5:0]            slot_r;
    logic [63:0]           shift_r;
    logic                  hold_full_r;
    logic [WORD_WIDTH-1:0] hold_left_r;
    logic [WORD_WIDTH-1:0] hold_right_r;

    logic                  accept_s;
    logic                  wrap_s;
    logic                  fall_s;
    logic                  load_s;
    logic [5:0]            slot_next_s;

    // Samples are MSB-aligned in a 32-bit slot; unused LSBs go out as zero.
    function automatic logic [31:0] align_slot(input logic [WORD_WIDTH-1:0] w);
        logic [31:0] t;
        t = 32'(w);
        return t << (32 - WORD_WIDTH);
    endfunction

    // Handshake acceptance, divider wrap and sck-fall/frame-load event decode.
    always_comb begin
        accept_s    = tx_valid && !hold_full_r;
        wrap_s      = 1'b0;
        fall_s      = 1'b0;
        load_s      = 1'b0;
        slot_next_s = slot_r + 6'd1;
        if ((state_r == RUN) && tx_en) begin
            wrap_s = (div_r == DIV_LAST);
            fall_s = wrap_s && sck_r;
            load_s = fall_s && (slot_next_s == 6'd1);
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Enable FSM: bit clock generation, slot sequencing and the output shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            div_r      <= 8'd0;
            sck_r      <= 1'b0;
            ws_r       <= 1'b0;
            slot_r     <= 6'd0;
            shift_r    <= 64'd0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    div_r   <= 8'd0;
                    sck_r   <= 1'b0;
                    ws_r    <= 1'b0;
                    slot_r  <= 6'd0;
                    shift_r <= 64'd0;
                    if (tx_en) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!tx_en) begin
                        // Partial frame is abandoned; the holding register is untouched.
                        state_r <= IDLE;
                        div_r   <= 8'd0;
                        sck_r   <= 1'b0;
                        ws_r    <= 1'b0;
                        slot_r  <= 6'd0;
                        shift_r <= 64'd0;
                    end else begin
                        if (wrap_s) begin
                            div_r <= 8'd0;
                            sck_r <= !sck_r;
                        end else begin
                            div_r <= div_r + 8'd1;
                        end
                        if (fall_s) begin
                            slot_r <= slot_next_s;
                            ws_r   <= slot_next_s[5];
                            if (load_s) begin
                                if (hold_full_r) begin
                                    shift_r <= {align_slot(hold_left_r), align_slot(hold_right_r)};
                                end else begin
                                    shift_r    <= 64'd0;
                                    underrun_r <= 1'b1;
                                end
                            end else begin
                                shift_r <= {shift_r[62:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Holding register: filled by the handshake, emptied by a frame load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full_r  <= 1'b0;
            hold_left_r  <= '0;
            hold_right_r <= '0;
        end else begin
            if (accept_s) begin
                hold_full_r  <= 1'b1;
                hold_left_r  <= data_left;
                hold_right_r <= data_right;
            end else if (load_s && hold_full_r) begin
                hold_full_r <= 1'b0;
            end else begin
                hold_full_r <= hold_full_r;
            end
        end
    end

    assign tx_ready = !hold_full_r;
    assign sck      = sck_r;
    assign ws       = ws_r;
    assign sd       = shift_r[63];
    assign underrun = underrun_r;

endmodule

// File: tb/tb_i2s_transmit.sv
// Bench for i2s_transmit: scoreboarded 32-bit / SCK_DIV=1 instance plus a
// table-driven 24-bit / SCK_DIV=4 instance.
module tb_i2s_transmit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, tx_en, tx_valid, tx_ready, sck, ws, sd, underrun;
    logic [31:0] data_left, data_right;
    logic        en2, valid2, ready2, sck2, ws2, sd2, und2;
    logic [23:0] l2, r2;

    i2s_transmit #(.SCK_DIV(1), .WORD_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .data_left(data_left), .data_right(data_right),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .sck(sck), .ws(ws), .sd(sd), .underrun(underrun)
    );

    i2s_transmit #(.SCK_DIV(4), .WORD_WIDTH(24)) dut24 (
        .clk(clk), .rst(rst), .tx_en(en2), .data_left(l2), .data_right(r2),
        .tx_valid(valid2), .tx_ready(ready2), .sck(sck2), .ws(ws2), .sd(sd2), .underrun(und2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Receiver/scoreboard state for the 32-bit instance
    logic        prev_sck = 1'b0;
    logic        en_prev  = 1'b0;
    logic        acc_pend = 1'b0;
    logic        load_now, exp_und;
    logic [63:0] acc_pair, rx_sr, exp_frame;
    logic [63:0] pend_q[$];
    logic [63:0] fly_q[$];
    int          k_m = 0;
    int          good_frames = 0;

    always @(negedge clk) begin
        if (!rst) begin
            pend_q.delete();
            fly_q.delete();
            acc_pend = 1'b0;
            k_m      = 0;
            rx_sr    = 64'd0;
            prev_sck = 1'b0;
            en_prev  = 1'b0;
        end else begin
            load_now = 1'b0;
            exp_und  = 1'b0;
            if (en_prev) begin
                if (sck && !prev_sck) begin
                    check("ws_slot", 64'(ws), (k_m >= 32) ? 64'd1 : 64'd0);
                    rx_sr = {rx_sr[62:0], sd};
                    if (k_m == 0 && fly_q.size() > 0) begin
                        exp_frame = fly_q.pop_front();
                        check("frame", rx_sr, exp_frame);
                        if (exp_frame != 64'd0 && rx_sr === exp_frame) good_frames++;
                    end
                end else if (!sck && prev_sck) begin
                    k_m = (k_m + 1) % 64;
                    if (k_m == 1) begin
                        load_now = 1'b1;
                        if (pend_q.size() > 0) begin
                            fly_q.push_back(pend_q.pop_front());
                        end else begin
                            fly_q.push_back(64'd0);
                            exp_und = 1'b1;
                        end
                    end
                end
            end
            check("underrun", 64'(underrun), 64'(exp_und));
            if (acc_pend) pend_q.push_back(acc_pair);
            acc_pend = tx_valid && tx_ready;
            acc_pair = {data_left, data_right};
            prev_sck = sck;
            if (!tx_en) begin
                k_m = 0;
                rx_sr = 64'd0;
                fly_q.delete();
                prev_sck = 1'b0;
            end
            en_prev = tx_en;
        end
    end

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
        int budget;
        budget = 0;
        tx_valid = 1'b1;
        data_left = l;
        data_right = r;
        @(negedge clk);
        while (!tx_ready && budget < 400) begin
            @(negedge clk);
            budget++;
        end
        if (!tx_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_pair: tx_ready got 0, expected 1 within 400 clk");
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_k(input int target);
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            #1;
            budget++;
        end while (k_m != target && budget < 300);
        if (k_m != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_k: slot got %0d, expected %0d within 300 clk", k_m, target);
        end
    endtask

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[4];

    int          toggles, rises, cyc, und_cnt, t1, t2, t65;
    logic        prev2, ws_k31, ws_k32;
    logic [63:0] frame2;

    initial begin
        tbl[0] = '{24'hFFFFFF, 24'h000000, 64'hFFFFFF00_00000000};
        tbl[1] = '{24'h800001, 24'hFFFFFF, 64'h80000100_FFFFFF00};
        tbl[2] = '{24'h123456, 24'hABCDEF, 64'h12345600_ABCDEF00};
        tbl[3] = '{24'h000000, 24'h000001, 64'h00000000_00000100};

        rst = 1'b0; tx_en = 1'b0; tx_valid = 1'b0; data_left = 32'd0; data_right = 32'd0;
        en2 = 1'b0; valid2 = 1'b0; l2 = 24'd0; r2 = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sck", 64'(sck), 64'd0);
        check("rst_ws", 64'(ws), 64'd0);
        check("rst_sd", 64'(sd), 64'd0);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        check("rst_underrun", 64'(underrun), 64'd0);
        rst = 1'b1;

        toggles = 0;
        repeat (200) begin
            @(negedge clk);
            if (sck !== 1'b0 || ws !== 1'b0 || sd !== 1'b0) toggles++;
        end
        check("idle_no_activity", 64'(toggles), 64'd0);

        // Pre-fill before enable, then stream with tx_valid held high
        @(posedge clk); #1;
        send_pair(32'hA5A5_0F0F, 32'h1234_5678);
        @(negedge clk);
        check("ready_low_when_full", 64'(tx_ready), 64'd0);
        @(posedge clk); #1;
        tx_en = 1'b1;
        for (int i = 0; i < 100; i++) send_pair($urandom(), $urandom());
        for (int i = 0; i < 3; i++) send_pair($urandom(), $urandom());
        repeat (4 * 128) @(posedge clk);

        // Drop enable mid-frame with a pair still held
        wait_k(10);
        wait_k(2);
        @(posedge clk); #1;
        send_pair(32'hCAFE_F00D, 32'h0BAD_BEEF);
        wait_k(40);
        @(posedge clk); #1;
        tx_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drop_sck", 64'(sck), 64'd0);
        check("drop_ws", 64'(ws), 64'd0);
        check("drop_sd", 64'(sd), 64'd0);
        check("drop_hold_kept", 64'(tx_ready), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        tx_en = 1'b1;
        repeat (3 * 128) @(posedge clk);
        @(negedge clk); #1;
        check("frames_delivered", 64'(good_frames), 64'd105);

        // Asynchronous reset in the middle of a data frame
        wait_k(10);
        wait_k(2);
        @(posedge clk); #1;
        send_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_k(10);
        wait_k(2);
        @(posedge clk); #1;
        send_pair(32'h1111_2222, 32'h3333_4444);
        wait_k(40);
        check("pre_rst_ws", 64'(ws), 64'd1);
        check("pre_rst_sd", 64'(sd), 64'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid_rst_sck", 64'(sck), 64'd0);
        check("mid_rst_ws", 64'(ws), 64'd0);
        check("mid_rst_sd", 64'(sd), 64'd0);
        check("mid_rst_underrun", 64'(underrun), 64'd0);
        check("mid_rst_ready", 64'(tx_ready), 64'd1);
        tx_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // 24-bit words, SCK_DIV=4: one pre-filled frame per table entry
        for (int v = 0; v < 4; v++) begin
            @(posedge clk); #1;
            l2 = tbl[v].l;
            r2 = tbl[v].r;
            valid2 = 1'b1;
            cyc = 0;
            @(negedge clk);
            while (!ready2 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("w24_ready", 64'(ready2), 64'd1);
            @(posedge clk); #1;
            valid2 = 1'b0;
            en2 = 1'b1;
            rises = 0; cyc = 0; und_cnt = 0; t1 = 0; t2 = 0; t65 = 0;
            prev2 = 1'b0; ws_k31 = 1'bx; ws_k32 = 1'bx; frame2 = 64'd0;
            while (rises < 65 && cyc < 2000) begin
                @(negedge clk);
                cyc++;
                if (und2) und_cnt++;
                if (sck2 && !prev2) begin
                    rises++;
                    if (rises == 1) t1 = cyc;
                    if (rises == 2) t2 = cyc;
                    if (rises == 65) t65 = cyc;
                    if (rises == 32) ws_k31 = ws2;
                    if (rises == 33) ws_k32 = ws2;
                    if (rises >= 2) frame2 = {frame2[62:0], sd2};
                end
                prev2 = sck2;
            end
            check("w24_rises", 64'(rises), 64'd65);
            check("w24_frame", frame2, tbl[v].exp);
            check("w24_sck_period", 64'(t2 - t1), 64'd8);
            check("w24_frame_period", 64'(t65 - t1), 64'd512);
            check("w24_ws_k31", 64'(ws_k31), 64'd0);
            check("w24_ws_k32", 64'(ws_k32), 64'd1);
            check("w24_no_underrun", 64'(und_cnt), 64'd0);
            @(posedge clk); #1;
            en2 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
